// File: rtl/mem_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through read.
module mem_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned AFULL_THRESH  = 28,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter int unsigned FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  REnable_i,
  input  logic                  WEnable_i,
  input  logic [DATA_WIDTH-1:0] Data_i,
  input  logic                  ClrErr_i,
  output logic [DATA_WIDTH-1:0] Data_o,
  output logic                  Valid_o,
  output logic                  Empty_o,
  output logic                  Full_o,
  output logic                  AlmostEmpty_o,
  output logic                  AlmostFull_o,
  output logic [ADDR_WIDTH:0]   Count_o,
  output logic                  Overflow_o,
  output logic                  Underflow_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  aempty_q, aempty_d;
  logic                  afull_q, afull_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_acc_c, wr_acc_c;

  // Acceptance, pointer/count update and flags derived from the next count
  always_comb begin
    rd_acc_c = REnable_i & ~empty_q;
    wr_acc_c = WEnable_i & (~full_q | rd_acc_c);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc_c) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d  = (count_d == CNT_W'(0));
    full_d   = (count_d == CNT_W'(DEPTH));
    aempty_d = (count_d <= CNT_W'(AEMPTY_THRESH));
    afull_d  = (count_d >= CNT_W'(AFULL_THRESH));

    // A new error on the same edge as a clear keeps the flag set
    ovf_d = (WEnable_i & ~wr_acc_c) | (ovf_q & ~ClrErr_i);
    udf_d = (REnable_i & ~rd_acc_c) | (udf_q & ~ClrErr_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; the pointers and count keep stale words hidden
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= Data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign Data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
      assign Valid_o = ~empty_q;
    end else begin : g_regrd
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc_c;
          if (rd_acc_c) data_q <= mem_q[rd_ptr_q];
        end
      end

      assign Data_o  = data_q;
      assign Valid_o = valid_q;
    end
  endgenerate

  assign Empty_o       = empty_q;
  assign Full_o        = full_q;
  assign AlmostEmpty_o = aempty_q;
  assign AlmostFull_o  = afull_q;
  assign Count_o       = count_q;
  assign Overflow_o    = ovf_q;
  assign Underflow_o   = udf_q;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl: registered-read instance plus an FWFT
// instance, with a queue of expected words checked as the FIFO emits them.
module tb_mem_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic          re = 1'b0, we = 1'b0, clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] d_o;
  logic          v_o, e_o, f_o, ae_o, af_o, ov_o, un_o;
  logic [AW:0]   cnt_o;

  logic          fre = 1'b0, fwe = 1'b0, fclr = 1'b0;
  logic [DW-1:0] fdin = '0;
  logic [DW-1:0] fd_o;
  logic          fv_o, fe_o, ff_o, fae_o, faf_o, fov_o, fun_o;
  logic [AW:0]   fcnt_o;

  int n_vec = 0;
  int n_err = 0;

  int            mcnt = 0;
  bit            movf = 1'b0, mudf = 1'b0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] fsb [$];

  always #5 clk = ~clk;

  mem_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(28),
                  .AEMPTY_THRESH(4), .FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .REnable_i(re), .WEnable_i(we), .Data_i(din),
    .ClrErr_i(clr), .Data_o(d_o), .Valid_o(v_o), .Empty_o(e_o), .Full_o(f_o),
    .AlmostEmpty_o(ae_o), .AlmostFull_o(af_o), .Count_o(cnt_o),
    .Overflow_o(ov_o), .Underflow_o(un_o));

  mem_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(28),
                  .AEMPTY_THRESH(4), .FWFT(1)) u_fw (
    .clk(clk), .reset(reset), .REnable_i(fre), .WEnable_i(fwe), .Data_i(fdin),
    .ClrErr_i(fclr), .Data_o(fd_o), .Valid_o(fv_o), .Empty_o(fe_o), .Full_o(ff_o),
    .AlmostEmpty_o(fae_o), .AlmostFull_o(faf_o), .Count_o(fcnt_o),
    .Overflow_o(fov_o), .Underflow_o(fun_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status();
    chk("count", 32'(cnt_o), 32'(mcnt));
    chk("empty", 32'(e_o), 32'(mcnt == 0));
    chk("full", 32'(f_o), 32'(mcnt == DEPTH));
    chk("aempty", 32'(ae_o), 32'(mcnt <= 4));
    chk("afull", 32'(af_o), 32'(mcnt >= 28));
    chk("ovf", 32'(ov_o), 32'(movf));
    chk("udf", 32'(un_o), 32'(mudf));
  endtask

  // Drive one cycle on the registered-read instance and check the result
  task automatic op(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    bit            racc, wacc;
    logic [DW-1:0] exp_d;
    exp_d = '0;
    racc = r && (mcnt > 0);
    wacc = w && ((mcnt < DEPTH) || racc);
    if (racc) exp_d = sb.pop_front();
    if (wacc) sb.push_back(d);
    movf = (w && !wacc) || (movf && !c);
    mudf = (r && !racc) || (mudf && !c);
    mcnt = mcnt + int'(wacc) - int'(racc);
    we = w; re = r; din = d; clr = c;
    tick();
    we = 1'b0; re = 1'b0; clr = 1'b0;
    chk_status();
    chk("valid", 32'(v_o), 32'(racc));
    if (racc) chk("rdata", 32'(d_o), 32'(exp_d));
  endtask

  task automatic chk_reset_vals();
    chk("rst_count", 32'(cnt_o), 32'd0);
    chk("rst_empty", 32'(e_o), 32'd1);
    chk("rst_full", 32'(f_o), 32'd0);
    chk("rst_aempty", 32'(ae_o), 32'd1);
    chk("rst_afull", 32'(af_o), 32'd0);
    chk("rst_data", 32'(d_o), 32'd0);
    chk("rst_valid", 32'(v_o), 32'd0);
    chk("rst_ovf", 32'(ov_o), 32'd0);
    chk("rst_udf", 32'(un_o), 32'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    fsb.delete();
    mcnt = 0;
    movf = 1'b0;
    mudf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w, r;
    // Reset held for two cycles, then released between edges
    tick();
    tick();
    chk_reset_vals();
    chk("frst_data", 32'(fd_o), 32'd0);
    chk("frst_valid", 32'(fv_o), 32'd0);
    chk("frst_empty", 32'(fe_o), 32'd1);
    reset = 1'b1;

    // Fill 0x00..0x1F then drain in order
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, DW'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0, 1'b0);

    // Overflow on full, underflow on empty, one clear drops both
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, DW'(8'h80 + i), 1'b0);
    op(1'b1, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0, 1'b0);
    op(1'b0, 1'b1, '0, 1'b0);
    op(1'b0, 1'b0, '0, 1'b1);
    op(1'b0, 1'b1, '0, 1'b1);
    op(1'b0, 1'b0, '0, 1'b1);

    // Simultaneous read/write at full, then at empty
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, DW'(8'hC0 + i), 1'b0);
    op(1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0, 1'b0);
    op(1'b1, 1'b1, 8'h11, 1'b0);
    op(1'b0, 1'b0, '0, 1'b1);

    // Interleaved traffic holding occupancy around the almost-empty boundary
    for (int i = 0; i < 100; i++) begin
      if (mcnt <= 3) begin
        w = 1'b1; r = 1'($urandom_range(0, 1));
      end else if (mcnt >= 6) begin
        r = 1'b1; w = 1'($urandom_range(0, 1));
      end else begin
        w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      end
      op(w, r, DW'($urandom_range(0, 255)), 1'b0);
    end

    // Asynchronous reset mid-burst at count 10, checked before any edge
    while (mcnt < 10) op(1'b1, 1'b0, DW'($urandom_range(0, 255)), 1'b0);
    chk("pre_rst_count", 32'(cnt_o), 32'd10);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    op(1'b1, 1'b0, 8'h5A, 1'b0);
    op(1'b0, 1'b1, '0, 1'b0);
    op(1'b0, 1'b0, '0, 1'b0);

    // First-word-fall-through instance
    fwe = 1'b1; fdin = 8'h3C; fsb.push_back(8'h3C);
    tick();
    fdin = 8'h7E; fsb.push_back(8'h7E);
    chk("fw_data0", 32'(fd_o), 32'(fsb[0]));
    chk("fw_valid0", 32'(fv_o), 32'd1);
    chk("fw_count0", 32'(fcnt_o), 32'd1);
    tick();
    fwe = 1'b0;
    chk("fw_head", 32'(fd_o), 32'(fsb[0]));
    fre = 1'b1;
    void'(fsb.pop_front());
    tick();
    chk("fw_data1", 32'(fd_o), 32'(fsb[0]));
    chk("fw_valid1", 32'(fv_o), 32'd1);
    void'(fsb.pop_front());
    tick();
    fre = 1'b0;
    chk("fw_valid2", 32'(fv_o), 32'd0);
    chk("fw_empty2", 32'(fe_o), 32'd1);
    chk("fw_udf2", 32'(fun_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_fifo_ctrl.md
Name: mem_fifo_ctrl

Overview:
Parametrised successor to the single-clock Mem FIFO. It adds the following:
- an occupancy count and programmable almost-full / almost-empty thresholds;
- sticky overflow / underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between the bridge request producer and consumer as the standard buffering element.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH entries, all usable
AFULL_THRESH, 28, AlmostFull_o asserted when count >= this value (legal range 1..DEPTH)
AEMPTY_THRESH, 4, AlmostEmpty_o asserted when count <= this value (legal range 0..DEPTH-1)
FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
REnable_i  in  1  read request / pop
WEnable_i  in  1  write request / push
Data_i  in  DATA_WIDTH  write data
ClrErr_i  in  1  synchronous clear of Overflow_o and Underflow_o
Data_o  out  DATA_WIDTH  read data
Valid_o  out  1  Data_o holds valid data (meaning depends on mode)
Empty_o  out  1  count == 0
Full_o  out  1  count == DEPTH
AlmostEmpty_o  out  1  count <= AEMPTY_THRESH
AlmostFull_o  out  1  count >= AFULL_THRESH
Count_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
Overflow_o  out  1  sticky: a write was attempted while full and no read accepted
Underflow_o  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (reset=0, asynchronous, any cycle including mid-transfer):
  - pointers=0, Count_o=0, Empty_o=1, Full_o=0.
  - AlmostEmpty_o=1, AlmostFull_o=0.
  - Data_o=0, Valid_o=0, Overflow_o=0, Underflow_o=0.
  - Memory contents are not cleared; stale entries are never visible.
  - Release of reset is synchronous-safe: the first accepted operation is on the edge after reset=1.
- Acceptance rules, evaluated each edge from registered state:
  - wr_acc = WEnable_i & (~Full_o | rd_acc)
  - rd_acc = REnable_i & ~Empty_o
  - Write into a full FIFO is accepted only if a read is accepted on the same edge.
  - Read from an empty FIFO is never accepted, even if a write occurs on the same edge.
- Pointers wrap modulo DEPTH; no extra wrap bit is used, because Count_o disambiguates full from empty.
- Count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
- All status flags are registered and computed from the next count, so they change on the same edge as Count_o. There is no one-cycle lag.
- Error flags:
  - Overflow_o sets on WEnable_i & ~wr_acc.
  - Underflow_o sets on REnable_i & ~rd_acc.
  - Both stay set until ClrErr_i=1 or reset.
  - If ClrErr_i and a new error occur on the same edge, the flag sets (the error wins).
  - A rejected operation never changes pointers, Count_o or memory.
- FWFT=0 (registered read):
  - On rd_acc, Data_o <= mem[rd_ptr] and Valid_o <= 1 on the next edge. Latency is 1 cycle from request.
  - When no read is accepted, Valid_o <= 0 and Data_o holds its last value.
- FWFT=1:
  - Data_o = mem[rd_ptr] combinationally, so the head word is always presented.
  - Valid_o = ~Empty_o.
  - REnable_i acts as the pop acknowledge for the presented word.
  - A word written into an empty FIFO appears on Data_o with Valid_o=1 one cycle after the write edge.
- Simultaneous read and write when full (count=DEPTH): both are accepted. The read returns the oldest word and the write lands in the freed slot; count stays DEPTH.
- Simultaneous read and write when empty: the write is accepted, the read is rejected and sets Underflow_o; count becomes 1.
- Memory write uses the write pointer before increment. In FWFT=0, a same-address read and write on one edge returns the old data.

Test Plan:
- Reset then idle: reset low for 2 cycles -> Empty_o=1, AlmostEmpty_o=1, Count_o=0, Data_o=0, all other outputs 0; assert reset low mid-burst at count=10 -> all outputs return to reset values immediately, without a clock edge.
- Fill/drain with FWFT=0: write 0x00..0x1F over 32 cycles -> Count_o=32, Full_o=1, AlmostFull_o asserted on the 28th write edge; then read 32 -> Data_o=0x00..0x1F in order, each with Valid_o=1 one cycle after its request, Empty_o=1 at the end.
- Overflow/underflow: when full, write 0xAA -> Overflow_o=1, Count_o stays 32, 0xAA never read out; when empty, read -> Underflow_o=1, Valid_o=0; ClrErr_i for 1 cycle -> both flags 0.
- Simultaneous operations: at count=32 with REnable_i=WEnable_i=1 and Data_i=0x55 -> Count_o=32, Overflow_o=0, and 0x55 is the last word drained; at count=0 with both high -> Count_o=1, Underflow_o=1.
- Wrap-around: run 100 interleaved push/pop cycles holding count between 3 and 6 -> read data matches a scoreboard, AlmostEmpty_o toggles exactly at the count 4/5 boundary.
- FWFT=1: write 0x3C into empty FIFO -> Data_o=0x3C with Valid_o=1 on the next cycle; pop -> Valid_o=0, Empty_o=1 on the same edge.
